// File: rtl/shr_serial_driver_if.sv
// Frame handshake between a frame producer and shr_serial_driver.
// The producer uses the master modport; the driver uses the slave modport.
interface shr_serial_driver_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] DIN;
    logic             DIN_VALID;
    logic             DIN_READY;

    modport master (output DIN, output DIN_VALID, input DIN_READY);
    modport slave  (input DIN, input DIN_VALID, output DIN_READY);
endinterface

// File: rtl/shr_serial_driver.sv
// Shifts parallel frames to an external shift register (SER_DATA/SER_CLK), then pulses SER_LATCH.
// Bit order: DIN[0] first by default; define SHR_MSB_FIRST_EN to send DIN[WIDTH-1] first.
module shr_serial_driver #(
    parameter int WIDTH   = 16,
    parameter int CLK_DIV = 4
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    shr_serial_driver_if.slave din_if,
    output logic               SER_DATA,
    output logic               SER_CLK,
    output logic               SER_LATCH,
    output logic               BUSY,
    output logic [7:0]         FRAME_CNT
);
    // state    | meaning
    // IDLE     | waiting for a frame, DIN_READY high
    // SHIFT_LO | SER_CLK low, current bit presented on SER_DATA
    // SHIFT_HI | SER_CLK high, external register samples SER_DATA
    // LATCH    | SER_LATCH pulse after the last bit

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LOAD = BIT_W'(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

    state_t           state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [BIT_W-1:0] bit_cnt, bit_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt, shreg_adv;
    logic             ser_clk_nxt, ser_latch_nxt, busy_nxt, ready_q, ready_nxt;
    logic [7:0]       frame_cnt_nxt;

    // The shift register empties to all zeros after WIDTH advances, so its
    // leading bit doubles as the registered SER_DATA (0 in LATCH and IDLE).
`ifdef SHR_MSB_FIRST_EN
    assign shreg_adv = {shreg[WIDTH-2:0], 1'b0};
    assign SER_DATA  = shreg[WIDTH-1];
`else
    assign shreg_adv = {1'b0, shreg[WIDTH-1:1]};
    assign SER_DATA  = shreg[0];
`endif

    assign din_if.DIN_READY = ready_q;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            SER_CLK   <= 1'b0;
            SER_LATCH <= 1'b0;
            BUSY      <= 1'b0;
            ready_q   <= 1'b0;
            FRAME_CNT <= 8'd0;
        end else begin
            state     <= state_nxt;
            div_cnt   <= div_nxt;
            bit_cnt   <= bit_nxt;
            shreg     <= shreg_nxt;
            SER_CLK   <= ser_clk_nxt;
            SER_LATCH <= ser_latch_nxt;
            BUSY      <= busy_nxt;
            ready_q   <= ready_nxt;
            FRAME_CNT <= frame_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        div_nxt       = div_cnt;
        bit_nxt       = bit_cnt;
        shreg_nxt     = shreg;
        ser_clk_nxt   = 1'b0;
        ser_latch_nxt = 1'b0;
        busy_nxt      = BUSY;
        ready_nxt     = ready_q;
        frame_cnt_nxt = FRAME_CNT;
        case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                busy_nxt  = 1'b0;
                if (din_if.DIN_VALID && ready_q) begin
                    shreg_nxt = din_if.DIN;
                    bit_nxt   = BIT_LOAD;
                    div_nxt   = DIV_LOAD;
                    state_nxt = SHIFT_LO;
                    ready_nxt = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end
            SHIFT_LO: begin
                if (div_cnt == '0) begin
                    state_nxt   = SHIFT_HI;
                    div_nxt     = DIV_LOAD;
                    ser_clk_nxt = 1'b1;
                end else begin
                    div_nxt = div_cnt - 1'b1;
                end
            end
            SHIFT_HI: begin
                ser_clk_nxt = 1'b1;
                if (div_cnt == '0) begin
                    ser_clk_nxt = 1'b0;
                    shreg_nxt   = shreg_adv;
                    bit_nxt     = bit_cnt - 1'b1;
                    div_nxt     = DIV_LOAD;
                    if (bit_cnt == BIT_W'(1)) begin
                        state_nxt     = LATCH;
                        ser_latch_nxt = 1'b1;
                    end else begin
                        state_nxt = SHIFT_LO;
                    end
                end else begin
                    div_nxt = div_cnt - 1'b1;
                end
            end
            LATCH: begin
                ser_latch_nxt = 1'b1;
                if (div_cnt == '0) begin
                    ser_latch_nxt = 1'b0;
                    busy_nxt      = 1'b0;
                    ready_nxt     = 1'b1;
                    frame_cnt_nxt = FRAME_CNT + 8'd1;
                    state_nxt     = IDLE;
                end else begin
                    div_nxt = div_cnt - 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_shr_serial_driver.sv
// Bench for shr_serial_driver (WIDTH=8, CLK_DIV=2); bit order follows SHR_MSB_FIRST_EN.
// Checks frame bits, timing, mid-frame reset and FRAME_CNT wrap against a simple model.
module tb_shr_serial_driver;
    localparam int W        = 8;
    localparam int DIV      = 2;
    localparam int BUSY_LEN = 2 * DIV * W + DIV;
    localparam int NFRAMES  = 256;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N;
    logic       SER_DATA, SER_CLK, SER_LATCH, BUSY;
    logic [7:0] FRAME_CNT;

    shr_serial_driver_if #(.WIDTH(W)) dif ();

    shr_serial_driver #(.WIDTH(W), .CLK_DIV(DIV)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .din_if   (dif),
        .SER_DATA (SER_DATA),
        .SER_CLK  (SER_CLK),
        .SER_LATCH(SER_LATCH),
        .BUSY     (BUSY),
        .FRAME_CNT(FRAME_CNT)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    // Observation record built at the negative edge, away from the active edge.
    logic rise_q[$];
    int   accept_q[$];
    int   fc_at_accept[$];
    int   busy_total = 0, latch_total = 0, overlap_total = 0;
    int   data_viol = 0, latch_data_viol = 0;
    logic prev_clk = 1'b0, prev_data = 1'b0;
    logic [W-1:0] frames [NFRAMES];

    always @(negedge CLOCK_50) begin
        if (RESET_N === 1'b1) begin
            if (SER_CLK === 1'b1 && prev_clk !== 1'b1) rise_q.push_back(SER_DATA);
            if (BUSY === 1'b1) busy_total++;
            if (SER_LATCH === 1'b1) latch_total++;
            if (SER_LATCH === 1'b1 && SER_CLK === 1'b1) overlap_total++;
            if (SER_CLK === 1'b1 && SER_DATA !== prev_data) data_viol++;
            if (SER_LATCH === 1'b1 && SER_DATA !== 1'b0) latch_data_viol++;
            if (dif.DIN_VALID === 1'b1 && dif.DIN_READY === 1'b1) begin
                accept_q.push_back(cyc);
                fc_at_accept.push_back(int'(FRAME_CNT));
            end
        end
        prev_clk  = SER_CLK;
        prev_data = SER_DATA;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Position i in the serial stream maps to this DIN bit.
    function automatic logic exp_bit(input logic [W-1:0] d, input int i);
`ifdef SHR_MSB_FIRST_EN
        return d[W-1-i];
`else
        return d[i];
`endif
    endfunction

    task automatic wait_accepts(input int n, input int budget);
        int c = 0;
        while (accept_q.size() < n && c < budget) begin
            @(posedge CLOCK_50);
            c++;
        end
        check("accept_wait", 64'(accept_q.size() >= n), 64'(1));
    endtask

    task automatic wait_rises(input int n, input int budget);
        int c = 0;
        while (rise_q.size() < n && c < budget) begin
            @(negedge CLOCK_50);
            c++;
        end
        check("rise_wait", 64'(rise_q.size() >= n), 64'(1));
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        @(negedge CLOCK_50);
        while (!(dif.DIN_READY === 1'b1 && BUSY === 1'b0) && c < budget) begin
            @(negedge CLOCK_50);
            c++;
        end
        check("idle_wait", 64'(dif.DIN_READY === 1'b1 && BUSY === 1'b0), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(dif.DIN_READY), 64'(0));
        check({tag, "_data"},  64'(SER_DATA),      64'(0));
        check({tag, "_clk"},   64'(SER_CLK),       64'(0));
        check({tag, "_latch"}, 64'(SER_LATCH),     64'(0));
        check({tag, "_busy"},  64'(BUSY),          64'(0));
        check({tag, "_fcnt"},  64'(FRAME_CNT),     64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] d0, d1, d2;
        int b0, l0, r0, a0, ov0, exp_fc;

        RESET_N       = 1'b0;
        dif.DIN       = '0;
        dif.DIN_VALID = 1'b0;
        exp_fc        = 0;
        repeat (3) @(negedge CLOCK_50);
        check_reset_outputs("reset");

        RESET_N = 1'b1;
        @(posedge CLOCK_50);
        #1;
        check("ready_after_release", 64'(dif.DIN_READY), 64'(1));

        // Directed frame 0x1E
        d0 = 8'h1E;
        b0 = busy_total; l0 = latch_total; r0 = rise_q.size(); a0 = accept_q.size();
        dif.DIN = d0; dif.DIN_VALID = 1'b1;
        wait_accepts(a0 + 1, 20);
        #1;
        dif.DIN_VALID = 1'b0;
        dif.DIN       = W'($urandom);
        @(negedge CLOCK_50);
        check("busy_after_accept", 64'(BUSY), 64'(1));
        check("ready_after_accept", 64'(dif.DIN_READY), 64'(0));
        wait_idle(4 * BUSY_LEN);
        check("rise_count_1e", 64'(rise_q.size() - r0), 64'(W));
        for (int i = 0; i < W; i++)
            check($sformatf("bit_1e_%0d", i), 64'(rise_q[r0 + i]), 64'(exp_bit(d0, i)));
        check("latch_cycles", 64'(latch_total - l0), 64'(DIV));
        check("busy_cycles", 64'(busy_total - b0), 64'(BUSY_LEN));
        exp_fc++;
        check("fcnt_after_1e", 64'(FRAME_CNT), 64'(exp_fc));

        // VALID held high, DIN changed mid-frame
        d0 = W'($urandom); d1 = W'($urandom);
        r0 = rise_q.size(); a0 = accept_q.size();
        dif.DIN = d0; dif.DIN_VALID = 1'b1;
        wait_accepts(a0 + 1, 20);
        repeat (10) @(posedge CLOCK_50);
        #1;
        dif.DIN = d1;
        wait_accepts(a0 + 2, 2 * BUSY_LEN);
        #1;
        dif.DIN_VALID = 1'b0;
        dif.DIN       = W'($urandom);
        check("accept_gap", 64'(accept_q[a0 + 1] - accept_q[a0]), 64'(BUSY_LEN + 1));
        wait_idle(4 * BUSY_LEN);
        check("rise_count_pair", 64'(rise_q.size() - r0), 64'(2 * W));
        for (int i = 0; i < W; i++) begin
            check($sformatf("bit_first_%0d", i), 64'(rise_q[r0 + i]), 64'(exp_bit(d0, i)));
            check($sformatf("bit_second_%0d", i), 64'(rise_q[r0 + W + i]), 64'(exp_bit(d1, i)));
        end
        exp_fc += 2;
        check("fcnt_after_pair", 64'(FRAME_CNT), 64'(exp_fc));

        // Reset during the 4th bit
        d2 = W'($urandom);
        r0 = rise_q.size(); a0 = accept_q.size(); l0 = latch_total;
        dif.DIN = d2; dif.DIN_VALID = 1'b1;
        wait_accepts(a0 + 1, 20);
        #1;
        dif.DIN_VALID = 1'b0;
        wait_rises(r0 + 3, 4 * BUSY_LEN);
        repeat (3) @(posedge CLOCK_50);
        #3;
        RESET_N = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (2) @(negedge CLOCK_50);
        check_reset_outputs("abort_hold");
        RESET_N = 1'b1;
        @(posedge CLOCK_50);
        #1;
        check("ready_after_abort", 64'(dif.DIN_READY), 64'(1));
        repeat (2 * BUSY_LEN) @(negedge CLOCK_50);
        check("abort_no_latch", 64'(latch_total - l0), 64'(0));
        check("abort_fcnt", 64'(FRAME_CNT), 64'(0));
        check("abort_busy", 64'(BUSY), 64'(0));
        exp_fc = 0;

        // Back-to-back frames through FRAME_CNT wrap
        for (int k = 0; k < NFRAMES; k++) frames[k] = W'($urandom);
        r0 = rise_q.size(); a0 = accept_q.size(); ov0 = overlap_total;
        dif.DIN = frames[0]; dif.DIN_VALID = 1'b1;
        for (int k = 0; k < NFRAMES; k++) begin
            wait_accepts(a0 + k + 1, 2 * BUSY_LEN);
            #1;
            if (k < NFRAMES - 1) dif.DIN = frames[k + 1];
            else dif.DIN_VALID = 1'b0;
        end
        wait_idle(4 * BUSY_LEN);
        check("rise_count_b2b", 64'(rise_q.size() - r0), 64'(NFRAMES * W));
        for (int k = 0; k < NFRAMES; k++) begin
            check($sformatf("fcnt_at_accept_%0d", k), 64'(fc_at_accept[a0 + k]), 64'(k % 256));
            if (k > 0)
                check($sformatf("b2b_gap_%0d", k), 64'(accept_q[a0 + k] - accept_q[a0 + k - 1]),
                      64'(BUSY_LEN + 1));
            for (int i = 0; i < W; i++)
                check($sformatf("b2b_bit_%0d_%0d", k, i), 64'(rise_q[r0 + k * W + i]),
                      64'(exp_bit(frames[k], i)));
        end
        exp_fc = (exp_fc + NFRAMES) % 256;
        check("fcnt_wrap", 64'(FRAME_CNT), 64'(exp_fc));
        check("clk_latch_overlap", 64'(overlap_total - ov0), 64'(0));
        check("data_change_clk_high", 64'(data_viol), 64'(0));
        check("data_during_latch", 64'(latch_data_viol), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/shr_serial_driver.md
SHR_SERIAL_DRIVER -- requirements
Module: shr_serial_driver

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the bits per frame; legal range 2..64.
REQ-002 The block SHALL have parameter CLK_DIV, default 4, giving the CLOCK_50 cycles per SER_CLK half-period; legal range >=1.
REQ-003 The block SHALL have port CLOCK_50, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RESET_N, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port DIN, input, WIDTH bits: parallel frame to shift out.
REQ-006 The block SHALL have port DIN_VALID, input, 1 bit: DIN holds a frame.
REQ-007 The block SHALL have port DIN_READY, output, 1 bit: block can accept a frame.
REQ-008 The block SHALL have port SER_DATA, output, 1 bit: serial data to the external shift register (GPIO).
REQ-009 The block SHALL have port SER_CLK, output, 1 bit: shift clock; the external register samples SER_DATA on its rising edge.
REQ-010 The block SHALL have port SER_LATCH, output, 1 bit: storage-register latch pulse.
REQ-011 The block SHALL have port BUSY, output, 1 bit: a frame is in progress (suitable for an LED).
REQ-012 The block SHALL have port FRAME_CNT, output, 8 bits: count of completed frames.

Function
REQ-013 The FSM SHALL have states IDLE, SHIFT_LO, SHIFT_HI and LATCH; all outputs SHALL be driven from registers (no combinational paths from input to output).
REQ-014 In IDLE: DIN_READY=1, BUSY=0, SER_CLK=0, SER_LATCH=0.
REQ-015 A frame SHALL be accepted on the edge where DIN_VALID=1 and DIN_READY=1: DIN is captured, the bit counter is set to WIDTH, the next state is SHIFT_LO, and DIN_READY=0 / BUSY=1 from the next cycle.
REQ-016 DIN_VALID while DIN_READY=0 SHALL be ignored; DIN SHALL be sampled only at acceptance.
REQ-017 SHIFT_LO SHALL last CLK_DIV cycles with SER_CLK=0 and SER_DATA = the current bit, then go to SHIFT_HI.
REQ-018 SHIFT_HI SHALL last CLK_DIV cycles with SER_CLK=1 and SER_DATA held stable.
REQ-019 On SHIFT_HI exit the shift register SHALL advance one bit and the counter SHALL decrement; if the counter reaches 0 the next state is LATCH, else SHIFT_LO.
REQ-020 LATCH SHALL last CLK_DIV cycles with SER_LATCH=1, SER_CLK=0 and SER_DATA=0, then return to IDLE and increment FRAME_CNT by 1 (255 wraps to 0).
REQ-021 Busy duration SHALL be exactly 2*CLK_DIV*WIDTH + CLK_DIV cycles; IDLE lasts at least 1 cycle, so the accept-to-accept minimum is 2*CLK_DIV*WIDTH + CLK_DIV + 1 cycles.
REQ-022 SER_CLK and SER_LATCH SHALL never be high in the same cycle.
REQ-023 SER_DATA SHALL change only while SER_CLK=0.
REQ-024 A frame accepted in the same cycle IDLE is re-entered SHALL be impossible, because DIN_READY is registered and rises only on the first IDLE cycle.

Reset
REQ-025 While RESET_N=0: state=IDLE, DIN_READY=0, SER_DATA=0, SER_CLK=0, SER_LATCH=0, BUSY=0, FRAME_CNT=0, and the counters are 0.
REQ-026 DIN_READY SHALL rise on the first clock edge after RESET_N deasserts.
REQ-027 A reset during any state SHALL abort the frame with no SER_LATCH pulse and no FRAME_CNT increment.

Configuration
REQ-028 With macro SHR_MSB_FIRST_EN defined, bits SHALL be shifted DIN[WIDTH-1] first.
REQ-029 Without SHR_MSB_FIRST_EN, bits SHALL be shifted DIN[0] first; timing SHALL be identical in both builds.

Verification (WIDTH=8, CLK_DIV=2)
REQ-030 MSB-first build, DIN=0x1E accepted: the bench SHALL see SER_DATA at the 8 SER_CLK rises as 0,0,0,1,1,1,1,0, then SER_LATCH high 2 cycles, BUSY high 34 cycles, and FRAME_CNT=1.
REQ-031 LSB-first build, DIN=0x1E: the bench SHALL see SER_DATA at the rises as 0,1,1,1,1,0,0,0, with timing identical to REQ-030.
REQ-032 DIN_VALID held high continuously with DIN changed mid-frame: the first frame SHALL be unaffected, and the next accept SHALL occur exactly 35 cycles after the first.
REQ-033 RESET_N pulsed low during the 4th bit: the bench SHALL see all outputs at reset values, no SER_LATCH, FRAME_CNT=0, and DIN_READY=1 one cycle after release.
REQ-034 256 back-to-back frames: FRAME_CNT SHALL wrap 255->0, and SER_CLK/SER_LATCH SHALL never overlap.
